// File: rtl/alu_result_buffer_pkg.sv
// alu_result_buffer_pkg
//   Shared definitions for the ALU result buffer: flag bit positions inside
//   the 3-bit flag field, and the packed entry layout {rd, flags, result}
//   stored in each FIFO slot.
package alu_result_buffer_pkg;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_COUT = 1;
  localparam int FLAG_OVF  = 2;
  localparam int FLAG_W    = 3;

  // Width of one stored entry: {rd, flags, result}, result in the low bits.
  function automatic int entry_w(input int data_w, input int addr_w);
    return addr_w + FLAG_W + data_w;
  endfunction

  // Assemble the flag field so every user agrees on bit positions.
  function automatic logic [FLAG_W-1:0] pack_flags(input logic zero,
                                                   input logic cout,
                                                   input logic ovf);
    logic [FLAG_W-1:0] f;
    f            = '0;
    f[FLAG_ZERO] = zero;
    f[FLAG_COUT] = cout;
    f[FLAG_OVF]  = ovf;
    return f;
  endfunction

endpackage

// File: rtl/alu_result_fifo_mem.sv
// alu_result_fifo_mem
//   DEPTH x WIDTH storage for the result buffer. One synchronous write port
//   and one asynchronous read port (first-word-fall-through at the top).
//   The array has no reset: occupancy lives in the top level and gates
//   every output, so stale contents are never observable.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write slot
//   wdata  in   write data {rd, flags, result}
//   raddr  in   read slot
//   rdata  out  contents of raddr (combinational)
module alu_result_fifo_mem #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 40,
  parameter int AW    = 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_buffer.sv
// alu_result_buffer
//   In-order FIFO between the 32-bit ALU and register-file writeback.
//   Captures result, {overflow, cout, zero} flags and destination index,
//   and presents the head entry over a valid/ready handshake. Also keeps a
//   saturating count of accepted overflowing results.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   flush            discard all buffered entries (priority over push/pop)
//   in_valid/ready   ALU side handshake; in_ready = not full
//   in_result, in_zero, in_cout, in_overflow, in_rd   ALU entry fields
//   out_valid/ready  writeback side handshake; out_valid = not empty
//   out_result, out_flags, out_rd   head entry (zero when empty)
//   out_we           register write enable (suppressed for r0)
//   count            current occupancy
//   ovf_count        saturating overflow event counter (reset-only clear)
module alu_result_buffer
  import alu_result_buffer_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_result,
  input  logic                     in_zero,
  input  logic                     in_cout,
  input  logic                     in_overflow,
  input  logic [ADDR_W-1:0]        in_rd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_result,
  output logic [FLAG_W-1:0]        out_flags,
  output logic [ADDR_W-1:0]        out_rd,
  output logic                     out_we,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         ovf_count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = entry_w(DATA_W, ADDR_W);
  localparam logic [PTR_W:0]   FULL    = (PTR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] OVF_MAX = '1;

  logic [PTR_W-1:0]   head, tail;
  logic [PTR_W:0]     cnt;
  logic [CNT_W-1:0]   ovf_cnt;
  logic               push, pop;
  logic [ENTRY_W-1:0] wr_entry, head_entry;

  // Handshakes depend only on registered occupancy: no push-through when
  // full and no bypass when empty.
  assign in_ready  = (cnt != FULL);
  assign out_valid = (cnt != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign wr_entry = {in_rd, pack_flags(in_zero, in_cout, in_overflow), in_result};

  alu_result_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .AW    (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push && rst_n && !flush),
    .waddr (tail),
    .wdata (wr_entry),
    .raddr (head),
    .rdata (head_entry)
  );

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (PTR_W+1)'(1);
        2'b01:   cnt <= cnt - (PTR_W+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // A push discarded by flush never counts as an overflow event.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (!flush && push && in_overflow && (ovf_cnt != OVF_MAX)) begin
      ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end

  // Head fields are forced to zero when empty so stale memory never leaks.
  always_comb begin
    out_result = '0;
    out_flags  = '0;
    out_rd     = '0;
    if (out_valid) begin
      out_result = head_entry[DATA_W-1:0];
      out_flags  = head_entry[DATA_W +: FLAG_W];
      out_rd     = head_entry[DATA_W+FLAG_W +: ADDR_W];
    end
  end

  // r0 is hardwired; the entry still drains, it just does not write.
  assign out_we    = out_valid && (out_rd != '0);
  assign count     = cnt;
  assign ovf_count = ovf_cnt;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Scoreboard bench for alu_result_buffer. The reference model is a queue of
// expected entries plus an overflow tally; the monitor checks the DUT head
// against the queue front every cycle and pops on a handshake.
module tb_alu_result_buffer;

  localparam int DEPTH  = 2;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 2;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int OVF_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n, flush, in_valid, in_ready;
  logic [DATA_W-1:0] in_result;
  logic              in_zero, in_cout, in_overflow;
  logic [ADDR_W-1:0] in_rd;
  logic              out_valid, out_ready, out_we;
  logic [DATA_W-1:0] out_result;
  logic [2:0]        out_flags;
  logic [ADDR_W-1:0] out_rd;
  logic [CW-1:0]     count;
  logic [CNT_W-1:0]  ovf_count;

  alu_result_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_zero(in_zero), .in_cout(in_cout),
    .in_overflow(in_overflow), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .out_rd(out_rd),
    .out_we(out_we), .count(count), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] res;
    logic [2:0]        fl;   // {overflow, cout, zero}
    logic [ADDR_W-1:0] rd;
  } ent_t;

  ent_t exp_q[$];
  int   exp_ovf  = 0;
  bit   checking = 1'b0;
  int   popped   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT head/status against the model before each edge.
  always @(negedge clk) begin
    if (checking) begin
      check("in_ready",  64'(in_ready),  64'(exp_q.size() < DEPTH));
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      check("count",     64'(count),     64'(exp_q.size()));
      check("ovf_count", 64'(ovf_count), 64'(exp_ovf));
      if (exp_q.size() != 0) begin
        check("out_result", 64'(out_result), 64'(exp_q[0].res));
        check("out_flags",  64'(out_flags),  64'(exp_q[0].fl));
        check("out_rd",     64'(out_rd),     64'(exp_q[0].rd));
        check("out_we",     64'(out_we),     64'(exp_q[0].rd != 0));
        if (rst_n && !flush && out_ready) begin
          void'(exp_q.pop_front());
          popped = 1;
        end
      end else begin
        check("empty_result", 64'(out_result), 64'(0));
        check("empty_flags",  64'(out_flags),  64'(0));
        check("empty_rd",     64'(out_rd),     64'(0));
        check("empty_we",     64'(out_we),     64'(0));
      end
    end
  end

  // Drive one cycle of inputs, record the expected effect of the coming
  // edge, and return just after that edge.
  task automatic step(input logic rn, input logic fl, input logic v,
                      input logic [DATA_W-1:0] r, input logic [2:0] f,
                      input logic [ADDR_W-1:0] rd, input logic ordy);
    ent_t e;
    rst_n = rn; flush = fl; in_valid = v; in_result = r;
    in_zero = f[0]; in_cout = f[1]; in_overflow = f[2];
    in_rd = rd; out_ready = ordy;
    @(negedge clk); #1;
    if (!rn) begin
      exp_q.delete();
      exp_ovf  = 0;
      checking = 1'b1;
    end else if (fl) begin
      exp_q.delete();
    end else if (v && (exp_q.size() + popped) < DEPTH) begin
      e.res = r; e.fl = f; e.rd = rd;
      exp_q.push_back(e);
      if (f[2] && exp_ovf < OVF_MAX) exp_ovf++;
    end
    popped = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_result = '0;
    in_zero = 1'b0; in_cout = 1'b0; in_overflow = 1'b0; in_rd = '0;
    out_ready = 1'b0;
    #1;

    // Reset held two cycles with in_valid high.
    step(0, 0, 1, 32'h1234, 3'b100, 5'd9, 0);
    step(0, 0, 1, 32'h1234, 3'b100, 5'd9, 0);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready",  64'(in_ready),  64'(1));
    check("rst_count",     64'(count),     64'(0));
    check("rst_ovf",       64'(ovf_count), 64'(0));
    check("rst_result",    64'(out_result), 64'(0));

    // Single entry, one-cycle visibility, then drain.
    step(1, 0, 1, 32'h5, 3'b000, 5'd3, 0);
    check("single_valid", 64'(out_valid),  64'(1));
    check("single_res",   64'(out_result), 64'(32'h5));
    check("single_rd",    64'(out_rd),     64'(3));
    check("single_we",    64'(out_we),     64'(1));
    step(1, 0, 0, 32'h0, 3'b000, 5'd0, 1);
    check("drain_count", 64'(count),     64'(0));
    check("drain_valid", 64'(out_valid), 64'(0));

    // Fill, refused third push, ordered drain.
    step(1, 0, 1, 32'h11111111, 3'b010, 5'd1, 0);
    step(1, 0, 1, 32'h22222222, 3'b000, 5'd2, 0);
    check("full_count", 64'(count),    64'(2));
    check("full_ready", 64'(in_ready), 64'(0));
    step(1, 0, 1, 32'h33333333, 3'b000, 5'd3, 0);
    check("full_hold",  64'(count),      64'(2));
    check("full_head",  64'(out_result), 64'(32'h11111111));
    step(1, 0, 0, 32'h0, 3'b000, 5'd0, 1);
    check("order_2nd",   64'(out_result), 64'(32'h22222222));
    check("ready_again", 64'(in_ready),   64'(1));
    step(1, 0, 0, 32'h0, 3'b000, 5'd0, 1);
    check("order_empty", 64'(count), 64'(0));

    // r0 write suppression with zero flag.
    step(1, 0, 1, 32'h0, 3'b001, 5'd0, 0);
    check("r0_valid", 64'(out_valid), 64'(1));
    check("r0_we",    64'(out_we),    64'(0));
    check("r0_flags", 64'(out_flags), 64'(3'b001));
    step(1, 0, 0, 32'h0, 3'b000, 5'd0, 1);

    // Overflow counter saturation at 3.
    step(0, 0, 0, 32'h0, 3'b000, 5'd0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, 32'h80000000, 3'b100, 5'd7, (i != 0));
      check("ovf_sat",   64'(ovf_count), 64'((i < 3) ? i + 1 : 3));
      check("ovf_flags", 64'(out_flags), 64'(3'b100));
    end

    // Flush beats a same-cycle push; ovf_count survives the flush.
    step(1, 1, 1, 32'hDEAD, 3'b100, 5'd4, 0);
    check("flush_count", 64'(count),     64'(0));
    check("flush_valid", 64'(out_valid), 64'(0));
    check("flush_ovf",   64'(ovf_count), 64'(3));
    step(1, 0, 1, 32'hA, 3'b000, 5'd5, 0);
    step(1, 0, 1, 32'hB, 3'b000, 5'd6, 0);
    check("refill_count", 64'(count), 64'(2));
    step(0, 0, 1, 32'hC, 3'b000, 5'd7, 0);
    check("midrst_count", 64'(count),     64'(0));
    check("midrst_valid", 64'(out_valid), 64'(0));

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(63) != 0),
           ($urandom_range(15) == 0),
           ($urandom_range(3) != 0),
           $urandom,
           3'($urandom),
           ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom),
           ($urandom_range(2) != 0));
    end

    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
